// File: rtl/hazard_pipeline_regs_if.sv
// hazard_pipeline_regs_if: pipeline-register bus between fetch/decode/hazard logic and the tag chain
interface hazard_pipeline_regs_if #(parameter int REG_W = 5, parameter int INSTR_W = 32, parameter int CNT_W = 16);
  logic [INSTR_W-1:0] IF_Instr;
  logic               IF_ID_Pipeline_Enable;
  logic               ID_Control_NOP;
  logic               ID_Flush;
  logic               ID_RegWrite;
  logic               ID_MemRead;
  logic               ID_MemWrite;
  logic               ID_MemtoReg;
  logic [REG_W-1:0]   ID_Write_Reg;
  logic [INSTR_W-1:0] IF_ID_Instr;
  logic               IF_ID_Valid;
  logic [REG_W-1:0]   IF_ID_Reg_Rs;
  logic [REG_W-1:0]   IF_ID_Reg_Rt;
  logic               ID_EX_RegWrite;
  logic               ID_EX_MemRead;
  logic               ID_EX_MemWrite;
  logic               ID_EX_MemtoReg;
  logic [REG_W-1:0]   ID_EX_Reg_Rs;
  logic [REG_W-1:0]   ID_EX_Reg_Rt;
  logic [REG_W-1:0]   ID_EX_Reg_Rd;
  logic               EX_MEM_RegWrite;
  logic               EX_MEM_MemWrite;
  logic               EX_MEM_MemtoReg;
  logic [REG_W-1:0]   EX_MEM_Reg_Rs;
  logic [REG_W-1:0]   EX_MEM_Reg_Rt;
  logic [REG_W-1:0]   EX_MEM_Reg_Rd;
  logic               MEM_WB_RegWrite;
  logic               MEM_WB_MemtoReg;
  logic [REG_W-1:0]   MEM_WB_Reg_Rt;
  logic [REG_W-1:0]   MEM_WB_Reg_Rd;
  logic [CNT_W-1:0]   Stall_Count;
  logic [CNT_W-1:0]   Flush_Count;
  modport master (
    output IF_Instr, IF_ID_Pipeline_Enable, ID_Control_NOP, ID_Flush,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_Write_Reg,
    input  IF_ID_Instr, IF_ID_Valid, IF_ID_Reg_Rs, IF_ID_Reg_Rt,
           ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
           ID_EX_Reg_Rs, ID_EX_Reg_Rt, ID_EX_Reg_Rd,
           EX_MEM_RegWrite, EX_MEM_MemWrite, EX_MEM_MemtoReg,
           EX_MEM_Reg_Rs, EX_MEM_Reg_Rt, EX_MEM_Reg_Rd,
           MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_Reg_Rt, MEM_WB_Reg_Rd,
           Stall_Count, Flush_Count
  );
  modport slave (
    input  IF_Instr, IF_ID_Pipeline_Enable, ID_Control_NOP, ID_Flush,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_Write_Reg,
    output IF_ID_Instr, IF_ID_Valid, IF_ID_Reg_Rs, IF_ID_Reg_Rt,
           ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
           ID_EX_Reg_Rs, ID_EX_Reg_Rt, ID_EX_Reg_Rd,
           EX_MEM_RegWrite, EX_MEM_MemWrite, EX_MEM_MemtoReg,
           EX_MEM_Reg_Rs, EX_MEM_Reg_Rt, EX_MEM_Reg_Rd,
           MEM_WB_RegWrite, MEM_WB_MemtoReg, MEM_WB_Reg_Rt, MEM_WB_Reg_Rd,
           Stall_Count, Flush_Count
  );
endinterface

// File: rtl/hazard_pipeline_regs.sv
// hazard_pipeline_regs: IF/ID->ID/EX->EX/MEM->MEM/WB hazard-tag chain; STALL_COUNTER_EN adds saturating stall/flush counters
module hazard_pipeline_regs #(parameter int REG_W = 5, parameter int INSTR_W = 32, parameter int CNT_W = 16) (
  input logic clk,
  input logic reset,
  hazard_pipeline_regs_if.slave p
);
  logic bub;
  assign bub = p.ID_Control_NOP | ~p.IF_ID_Valid;
  assign p.IF_ID_Reg_Rs = p.IF_ID_Instr[21 +: REG_W];
  assign p.IF_ID_Reg_Rt = p.IF_ID_Instr[16 +: REG_W];
  // IF/ID: a stall freezes the stage (and the stalled branch's flush), otherwise flush squashes or fetch loads
  always_ff @(posedge clk or posedge reset)
    if (reset) {p.IF_ID_Instr, p.IF_ID_Valid} <= '0;
    else if (p.IF_ID_Pipeline_Enable) {p.IF_ID_Instr, p.IF_ID_Valid} <= p.ID_Flush ? '0 : {p.IF_Instr, 1'b1};
  // ID/EX: bubble on NOP request or an empty IF/ID, else capture decoded control and tags
  always_ff @(posedge clk or posedge reset)
    if (reset) {p.ID_EX_RegWrite, p.ID_EX_MemRead, p.ID_EX_MemWrite, p.ID_EX_MemtoReg,
                 p.ID_EX_Reg_Rs, p.ID_EX_Reg_Rt, p.ID_EX_Reg_Rd} <= '0;
    else {p.ID_EX_RegWrite, p.ID_EX_MemRead, p.ID_EX_MemWrite, p.ID_EX_MemtoReg,
          p.ID_EX_Reg_Rs, p.ID_EX_Reg_Rt, p.ID_EX_Reg_Rd} <= bub ? '0 :
         {p.ID_RegWrite, p.ID_MemRead, p.ID_MemWrite, p.ID_MemtoReg,
          p.IF_ID_Reg_Rs, p.IF_ID_Reg_Rt, p.ID_Write_Reg};
  // EX/MEM: free-running copy of ID/EX
  always_ff @(posedge clk or posedge reset)
    if (reset) {p.EX_MEM_RegWrite, p.EX_MEM_MemWrite, p.EX_MEM_MemtoReg,
                 p.EX_MEM_Reg_Rs, p.EX_MEM_Reg_Rt, p.EX_MEM_Reg_Rd} <= '0;
    else {p.EX_MEM_RegWrite, p.EX_MEM_MemWrite, p.EX_MEM_MemtoReg,
          p.EX_MEM_Reg_Rs, p.EX_MEM_Reg_Rt, p.EX_MEM_Reg_Rd} <=
         {p.ID_EX_RegWrite, p.ID_EX_MemWrite, p.ID_EX_MemtoReg,
          p.ID_EX_Reg_Rs, p.ID_EX_Reg_Rt, p.ID_EX_Reg_Rd};
  // MEM/WB: free-running copy of EX/MEM
  always_ff @(posedge clk or posedge reset)
    if (reset) {p.MEM_WB_RegWrite, p.MEM_WB_MemtoReg, p.MEM_WB_Reg_Rt, p.MEM_WB_Reg_Rd} <= '0;
    else {p.MEM_WB_RegWrite, p.MEM_WB_MemtoReg, p.MEM_WB_Reg_Rt, p.MEM_WB_Reg_Rd} <=
         {p.EX_MEM_RegWrite, p.EX_MEM_MemtoReg, p.EX_MEM_Reg_Rt, p.EX_MEM_Reg_Rd};
`ifdef STALL_COUNTER_EN
  logic flush_apply;
  assign flush_apply = p.ID_Flush & p.IF_ID_Pipeline_Enable;
  // Event counters: bubbles and applied flushes, saturating at all-ones
  always_ff @(posedge clk or posedge reset)
    if (reset) {p.Stall_Count, p.Flush_Count} <= '0;
    else begin
      if (p.ID_Control_NOP && !(&p.Stall_Count)) p.Stall_Count <= p.Stall_Count + 1'b1;
      if (flush_apply && !(&p.Flush_Count)) p.Flush_Count <= p.Flush_Count + 1'b1;
    end
`else
  assign p.Stall_Count = '0;
  assign p.Flush_Count = '0;
`endif
endmodule
